// File: rtl/alu_wide_seq.sv
// alu_wide_seq: runs 16-bit ADD/SUB/AND/OR on an external 8-bit alu
// in LO/HI byte passes plus an optional carry/borrow FIX pass.
module alu_wide_seq #(
  parameter bit FIX_ALWAYS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  cmd_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        carry_o,
  output logic        neg_o,
  output logic        zero_o,
  output logic [7:0]  alu_rs_o,
  output logic [7:0]  alu_rt_o,
  output logic [8:0]  alu_op_o,
  input  logic [7:0]  alu_result_i,
  input  logic        alu_carry_i
);

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_AND = 2'b10;
  localparam logic [1:0] CMD_OR  = 2'b11;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [1:0]  r_cmd;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic        r_c_lo;
  logic        r_c_hi;

  logic [15:0] r_result;
  logic        r_carry;
  logic        r_neg;
  logic        r_zero;

  logic        w_accept;
  logic        w_arith;
  logic        w_need_fix;
  logic [7:0]  w_op_code;
  logic [15:0] w_fin_res;
  logic        w_fin_carry;
  logic        w_finish;

  assign w_accept   = (r_state == S_IDLE) && start_i;
  assign w_arith    = (r_cmd == CMD_ADD) || (r_cmd == CMD_SUB);
  assign w_need_fix = w_arith && (r_c_lo || FIX_ALWAYS);

  always_comb begin
    w_op_code = OP_ADD;
    unique case (r_cmd)
      CMD_ADD: w_op_code = OP_ADD;
      CMD_SUB: w_op_code = OP_SUB;
      CMD_AND: w_op_code = OP_AND;
      CMD_OR:  w_op_code = OP_OR;
      default: w_op_code = OP_ADD;
    endcase
  end

  // The final high byte arrives from the alu in the same cycle we leave
  // HI or FIX, so the result and flags are formed from alu_result_i directly.
  assign w_fin_res = {alu_result_i, r_lo};

  always_comb begin
    w_fin_carry = 1'b0;
    if (r_state == S_FIX)
      w_fin_carry = r_c_hi | alu_carry_i;
    else
      w_fin_carry = w_arith & alu_carry_i;
  end

  assign w_finish = (r_state == S_FIX) ||
                    ((r_state == S_HI) && !w_need_fix);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start_i) w_next = S_LO;
      S_LO:   w_next = S_HI;
      S_HI:   w_next = w_need_fix ? S_FIX : S_DONE;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs and alu drive
  always_comb begin
    busy_o   = 1'b1;
    done_o   = 1'b0;
    alu_rs_o = 8'h00;
    alu_rt_o = 8'h00;
    alu_op_o = {OP_ADD, 1'b0};
    unique case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
      end
      S_LO: begin
        alu_rs_o = r_a[7:0];
        alu_rt_o = r_b[7:0];
        alu_op_o = {w_op_code, 1'b0};
      end
      S_HI: begin
        alu_rs_o = r_a[15:8];
        alu_rt_o = r_b[15:8];
        alu_op_o = {w_op_code, 1'b0};
      end
      S_FIX: begin
        alu_rs_o = r_hi;
        alu_rt_o = {7'b0, r_c_lo};
        alu_op_o = {w_op_code, 1'b0};
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Operand capture and byte pass results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= 16'h0000;
      r_b    <= 16'h0000;
      r_cmd  <= CMD_ADD;
      r_lo   <= 8'h00;
      r_hi   <= 8'h00;
      r_c_lo <= 1'b0;
      r_c_hi <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= a_i;
        r_b   <= b_i;
        r_cmd <= cmd_i;
      end
      if (r_state == S_LO) begin
        r_lo   <= alu_result_i;
        r_c_lo <= w_arith & alu_carry_i;
      end
      if (r_state == S_HI) begin
        r_hi   <= alu_result_i;
        r_c_hi <= w_arith & alu_carry_i;
      end
      if (r_state == S_FIX) begin
        r_hi   <= alu_result_i;
        r_c_hi <= r_c_hi | alu_carry_i;
      end
    end
  end

  // Result and flags, held until the next operation completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= 16'h0000;
      r_carry  <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_finish) begin
      r_result <= w_fin_res;
      r_carry  <= w_fin_carry;
      r_neg    <= w_fin_res[15];
      r_zero   <= (w_fin_res == 16'h0000);
    end
  end

  assign result_o = r_result;
  assign carry_o  = r_carry;
  assign neg_o    = r_neg;
  assign zero_o   = r_zero;

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: directed checks of alu_wide_seq with a
// behavioural 8-bit alu attached to each instance.
module tb_alu_wide_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0;
  logic        start1;
  logic [1:0]  cmd;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy0, done0, carry0, neg0, zero0, ac0;
  logic [15:0] res0;
  logic [7:0]  rs0, rt0, ar0;
  logic [8:0]  op0;

  logic        busy1, done1, carry1, neg1, zero1, ac1;
  logic [15:0] res1;
  logic [7:0]  rs1, rt1, ar1;
  logic [8:0]  op1;

  int checks = 0;
  int errors = 0;

  logic [8:0] tr_op [1:8];
  logic [7:0] tr_rs [1:8];
  logic [7:0] tr_rt [1:8];

  always #5 clk = ~clk;

  // opcodes: {8'h00,0}=ADD {8'h01,0}=SUB {8'h02,0}=AND {8'h03,0}=OR
  function automatic logic [8:0] alu_model(input logic [7:0] rs,
                                           input logic [7:0] rt,
                                           input logic [8:0] op);
    logic [8:0] r;
    case (op)
      9'h000:  r = {1'b0, rs} + {1'b0, rt};
      9'h002:  r = {1'b0, rs} - {1'b0, rt};
      9'h004:  r = {1'b0, rs & rt};
      default: r = {1'b0, rs | rt};
    endcase
    return r;
  endfunction

  assign {ac0, ar0} = alu_model(rs0, rt0, op0);
  assign {ac1, ar1} = alu_model(rs1, rt1, op1);

  alu_wide_seq #(.FIX_ALWAYS(1'b0)) u_dut (
    .clk(clk), .reset(rst), .start_i(start0), .cmd_i(cmd),
    .a_i(a), .b_i(b), .busy_o(busy0), .done_o(done0),
    .result_o(res0), .carry_o(carry0), .neg_o(neg0), .zero_o(zero0),
    .alu_rs_o(rs0), .alu_rt_o(rt0), .alu_op_o(op0),
    .alu_result_i(ar0), .alu_carry_i(ac0)
  );

  alu_wide_seq #(.FIX_ALWAYS(1'b1)) u_dut_fa (
    .clk(clk), .reset(rst), .start_i(start1), .cmd_i(cmd),
    .a_i(a), .b_i(b), .busy_o(busy1), .done_o(done1),
    .result_o(res1), .carry_o(carry1), .neg_o(neg1), .zero_o(zero1),
    .alu_rs_o(rs1), .alu_rt_o(rt1), .alu_op_o(op1),
    .alu_result_i(ar1), .alu_carry_i(ac1)
  );

  // Latency counts cycles from the one where start_i was high; -1 = timeout.
  task automatic issue(input bit sel, input logic [1:0] c,
                       input logic [15:0] x, input logic [15:0] y,
                       output int lat);
    int guard;
    lat = -1;
    guard = 0;
    while ((sel ? busy1 : busy0) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    cmd = c; a = x; b = y;
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tr_op[n] = sel ? op1 : op0;
      tr_rs[n] = sel ? rs1 : rs0;
      tr_rt[n] = sel ? rt1 : rt0;
      if (sel ? done1 : done0) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, carry0, neg0, zero0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {busy0, done0, carry0, neg0, zero0});
    end
    checks++;
    if (res0 !== 16'h0000 || res1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_result got %h/%h want 0000", res0, res1);
    end
    checks++;
    if ({rs0, rt0, op0} !== 25'h0) begin
      errors++;
      $display("FAIL reset_alu_drive got %h %h %h want 00 00 000",
               rs0, rt0, op0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_fix();
    int lat;
    issue(1'b0, 2'b00, 16'h00FF, 16'h0001, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_fix_latency got %0d want 4", lat);
    end
    checks++;
    if ({res0, carry0, neg0, zero0} !== {16'h0100, 3'b000}) begin
      errors++;
      $display("FAIL add_fix_result got %h c%b n%b z%b want 0100 c0 n0 z0",
               res0, carry0, neg0, zero0);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    issue(1'b0, 2'b00, 16'hFFFF, 16'h0001, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_wrap_latency got %0d want 4", lat);
    end
    checks++;
    if ({res0, carry0, neg0, zero0} !== {16'h0000, 3'b101}) begin
      errors++;
      $display("FAIL add_wrap_result got %h c%b n%b z%b want 0000 c1 n0 z1",
               res0, carry0, neg0, zero0);
    end
    checks++;
    if ({tr_op[3], tr_rs[3], tr_rt[3]} !== {9'h000, 8'hFF, 8'h01}) begin
      errors++;
      $display("FAIL add_wrap_fix_drive got op %h rs %h rt %h want 000 ff 01",
               tr_op[3], tr_rs[3], tr_rt[3]);
    end
  endtask

  task automatic test_sub_borrow();
    int lat;
    issue(1'b0, 2'b01, 16'h0000, 16'h0001, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL sub_borrow_latency got %0d want 4", lat);
    end
    checks++;
    if ({res0, carry0, neg0, zero0} !== {16'hFFFF, 3'b110}) begin
      errors++;
      $display("FAIL sub_borrow_result got %h c%b n%b z%b want ffff c1 n1 z0",
               res0, carry0, neg0, zero0);
    end
    checks++;
    if ({tr_op[3], tr_rt[3]} !== {9'h002, 8'h01}) begin
      errors++;
      $display("FAIL sub_borrow_fix_drive got op %h rt %h want 002 01",
               tr_op[3], tr_rt[3]);
    end
  endtask

  task automatic test_sub_nofix();
    int lat;
    issue(1'b0, 2'b01, 16'h1234, 16'h0034, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL sub_nofix_latency got %0d want 3", lat);
    end
    checks++;
    if ({res0, carry0, neg0, zero0} !== {16'h1200, 3'b000}) begin
      errors++;
      $display("FAIL sub_nofix_result got %h c%b n%b z%b want 1200 c0 n0 z0",
               res0, carry0, neg0, zero0);
    end
  endtask

  task automatic test_logic();
    int lat;
    issue(1'b0, 2'b10, 16'hF0F0, 16'h0FF0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL and_latency got %0d want 3", lat);
    end
    checks++;
    if ({res0, carry0, neg0, zero0} !== {16'h00F0, 3'b000}) begin
      errors++;
      $display("FAIL and_result got %h c%b n%b z%b want 00f0 c0 n0 z0",
               res0, carry0, neg0, zero0);
    end
    issue(1'b0, 2'b11, 16'h8000, 16'h0001, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL or_latency got %0d want 3", lat);
    end
    checks++;
    if ({res0, carry0, neg0, zero0} !== {16'h8001, 3'b010}) begin
      errors++;
      $display("FAIL or_result got %h c%b n%b z%b want 8001 c0 n1 z0",
               res0, carry0, neg0, zero0);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    lat = -1;
    @(posedge clk); #1;
    cmd = 2'b00; a = 16'h0100; b = 16'h0200;
    start0 = 1'b1;
    @(posedge clk); #1;
    cmd = 2'b01; a = 16'hFFFF; b = 16'h0001;
    for (int n = 1; n <= 8; n++) begin
      if (done0) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL ignore_latency got %0d want 3", lat);
    end
    checks++;
    if ({res0, carry0} !== {16'h0300, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result got %h c%b want 0300 c0", res0, carry0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_second got busy %b want 0", busy0);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(1'b0, 2'b00, 16'h7FFF, 16'h0001, lat);
    checks++;
    if (lat !== 4 || {res0, carry0, neg0, zero0} !== {16'h8000, 3'b010}) begin
      errors++;
      $display("FAIL b2b_first got lat %0d %h c%b n%b z%b want 4 8000 c0 n1 z0",
               lat, res0, carry0, neg0, zero0);
    end
    @(posedge clk); #1;
    checks++;
    if ({done0, busy0, res0} !== {2'b00, 16'h8000}) begin
      errors++;
      $display("FAIL b2b_pulse got done %b busy %b res %h want 0 0 8000",
               done0, busy0, res0);
    end
    issue(1'b0, 2'b11, 16'h0000, 16'h0000, lat);
    checks++;
    if (lat !== 3 || {res0, carry0, neg0, zero0} !== {16'h0000, 3'b001}) begin
      errors++;
      $display("FAIL b2b_second got lat %0d %h c%b n%b z%b want 3 0000 c0 n0 z1",
               lat, res0, carry0, neg0, zero0);
    end
  endtask

  task automatic test_fix_always();
    int lat;
    issue(1'b1, 2'b00, 16'h0001, 16'h0001, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL fa_add_latency got %0d want 4", lat);
    end
    checks++;
    if ({res1, carry1, neg1, zero1} !== {16'h0002, 3'b000}) begin
      errors++;
      $display("FAIL fa_add_result got %h c%b n%b z%b want 0002 c0 n0 z0",
               res1, carry1, neg1, zero1);
    end
    issue(1'b1, 2'b10, 16'hFFFF, 16'h00FF, lat);
    checks++;
    if (lat !== 3 || res1 !== 16'h00FF) begin
      errors++;
      $display("FAIL fa_and got lat %0d res %h want 3 00ff", lat, res1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    cmd = 2'b00; a = 16'h12FF; b = 16'h0001;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy0, rs0} !== {1'b1, 8'h12}) begin
      errors++;
      $display("FAIL rmid_in_hi got busy %b rs %h want 1 12", busy0, rs0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, res0, carry0, neg0, zero0} !== 20'h0) begin
      errors++;
      $display("FAIL rmid_abort got busy %b done %b res %h c%b n%b z%b want all 0",
               busy0, done0, res0, carry0, neg0, zero0);
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (done0) seen = 1'b1;
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (done0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmid_no_done got done seen %b want 0", seen);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    cmd    = 2'b00;
    a      = 16'h0000;
    b      = 16'h0000;
    test_reset();
    test_add_fix();
    test_add_wrap();
    test_sub_borrow();
    test_sub_nofix();
    test_logic();
    test_ignore_start();
    test_back_to_back();
    test_fix_always();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
